// File: rtl/lsu_unit.sv
// Load/store unit: decodes rv32i loads/stores, runs one data-bus transaction,
// and returns aligned, extended load data or a store completion to writeback.
module lsu_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [16:0] full_op,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] ea_q, sd_q, data_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        ld_q, err_q;
    logic [15:0] cnt_q;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] ea;
    logic        dec_ld, dec_st, mis, dec_err, accept;
    logic        unused_funct7;

    assign opc           = full_op[6:0];
    assign f3            = full_op[9:7];
    assign unused_funct7 = ^full_op[16:10];
    assign ea            = base + offset;
    assign accept        = req_valid && (state_q == IDLE);

    always_comb begin
        dec_ld = 1'b0;
        dec_st = 1'b0;
        mis    = 1'b0;
        if (opc == 7'b0000011) begin
            case (f3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101: dec_ld = 1'b1;
                default:        dec_ld = 1'b0;
            endcase
        end
        if (opc == 7'b0100011) begin
            case (f3)
                3'b000, 3'b001, 3'b010: dec_st = 1'b1;
                default:                dec_st = 1'b0;
            endcase
        end
        case (f3[1:0])
            2'b01:   mis = ea[0];
            2'b10:   mis = |ea[1:0];
            default: mis = 1'b0;
        endcase
    end

    assign dec_err = !(dec_ld || dec_st) || mis;

    // Store lane placement from the latched address and data
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = sd_q;
        case (f3_q[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << ea_q[1:0];
                st_wdata = {4{sd_q[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << ea_q[1:0];
                st_wdata = {2{sd_q[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = sd_q;
            end
        endcase
    end

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;
    always_comb begin
        case (ea_q[1:0])
            2'b00:   ld_b = mem_rdata[7:0];
            2'b01:   ld_b = mem_rdata[15:8];
            2'b10:   ld_b = mem_rdata[23:16];
            default: ld_b = mem_rdata[31:24];
        endcase
        ld_h = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_ext = {24'd0, ld_b};
            3'b101:  ld_ext = {16'd0, ld_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = dec_err ? RESP : REQ;
            REQ:  if (mem_ready) state_d = ld_q ? WAIT : RESP;
            WAIT: if (mem_rvalid || cnt_q == WAIT_LAST) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_req    = (state_q == REQ);
        mem_we     = mem_req && !ld_q;
        mem_addr   = mem_req ? {ea_q[31:2], 2'b00} : 32'd0;
        mem_wdata  = mem_we ? st_wdata : 32'd0;
        mem_wstrb  = mem_we ? st_strb : 4'd0;
        resp_valid = (state_q == RESP);
        resp_data  = resp_valid ? data_q : 32'd0;
        resp_err   = resp_valid && err_q;
        resp_rd    = (resp_valid && ld_q && !err_q) ? rd_q : 5'd0;
    end

    // Transaction context; data_q stays 0 for stores, errors and timeouts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ea_q   <= '0;
            sd_q   <= '0;
            data_q <= '0;
            f3_q   <= '0;
            rd_q   <= '0;
            ld_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            ea_q   <= ea;
            sd_q   <= store_data;
            data_q <= '0;
            f3_q   <= f3;
            rd_q   <= rd_in;
            ld_q   <= dec_ld;
            err_q  <= dec_err;
            cnt_q  <= '0;
        end else if (state_q == WAIT) begin
            if (mem_rvalid) begin
                data_q <= ld_ext;
            end else begin
                cnt_q <= cnt_q + 16'd1;
                if (cnt_q == WAIT_LAST) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed self-checking bench for lsu_unit (MAX_WAIT=4 so the load
// timeout is reachable in a few cycles).
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [16:0] full_op;
    logic [31:0] base, offset, store_data;
    logic [4:0]  rd_in;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    lsu_unit #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .full_op    (full_op),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .rd_in      (rd_in),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [6:0] opc,
                         input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] sd, input logic [4:0] rd);
        full_op    = {7'b0100000, f3, opc};
        base       = b;
        offset     = o;
        store_data = sd;
        rd_in      = rd;
        req_valid  = 1'b1;
        chk("accept_ready", req_ready, 1);
        step();
        req_valid  = 1'b0;
    endtask

    // Zero-wait load: REQ in cycle 1, rvalid in cycle 2, resp in cycle 3
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] b, input logic [31:0] o,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        mem_ready = 1'b1;
        issue(f3, OP_LD, b, o, 32'h0, rd);
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_wstrb"}, mem_wstrb, 0);
        step();
        chk({tag, "_wait_noreq"}, mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_rd"}, resp_rd, rd);
        chk({tag, "_err"}, resp_err, 0);
        step();
        chk({tag, "_pulse"}, resp_valid, 0);
    endtask

    // Zero-wait store: REQ in cycle 1, resp in cycle 2, IDLE in cycle 3
    task automatic do_store(input string tag, input logic [2:0] f3,
                            input logic [31:0] b, input logic [31:0] o,
                            input logic [31:0] sd,
                            input logic [31:0] exp_addr,
                            input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        mem_ready = 1'b1;
        issue(f3, OP_ST, b, o, sd, 5'd9);
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_we"}, mem_we, 1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_wstrb"}, mem_wstrb, exp_strb);
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        step();
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_err"}, resp_err, 0);
        chk({tag, "_data"}, resp_data, 0);
        chk({tag, "_rd"}, resp_rd, 0);
        step();
        chk({tag, "_idle"}, req_ready, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        full_op    = '0;
        base       = '0;
        offset     = '0;
        store_data = '0;
        rd_in      = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_wdata", mem_wdata, 0);
        step();
        rst_n = 1'b1;
        step();

        // LB at 0x1003: byte 3 of 0x80A5C3F0 = 0x80, sign-extended
        do_load("lb", 3'b000, 32'h1000, 32'h3, 5'd5, 32'h80A5C3F0,
                32'h1000, 32'hFFFFFF80);

        // SH at 0x2002 with 3 stall cycles on the bus
        mem_ready = 1'b0;
        issue(3'b001, OP_ST, 32'h2000, 32'h2, 32'h1234BEEF, 5'd7);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            chk("sh_req", mem_req, 1);
            chk("sh_we", mem_we, 1);
            chk("sh_addr", mem_addr, 32'h2000);
            chk("sh_wstrb", mem_wstrb, 4'b1100);
            chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
            chk("sh_novalid", resp_valid, 0);
            step();
        end
        chk("sh_valid", resp_valid, 1);
        chk("sh_err", resp_err, 0);
        chk("sh_data", resp_data, 0);
        chk("sh_rd", resp_rd, 0);
        step();

        // Misaligned LW and unsupported funct3: error at cycle 1, no bus
        issue(3'b010, OP_LD, 32'h1000, 32'h2, 32'h0, 5'd3);
        chk("lw_mis_noreq", mem_req, 0);
        chk("lw_mis_valid", resp_valid, 1);
        chk("lw_mis_err", resp_err, 1);
        chk("lw_mis_data", resp_data, 0);
        chk("lw_mis_rd", resp_rd, 0);
        step();
        issue(3'b011, OP_LD, 32'h1000, 32'h0, 32'h0, 5'd3);
        chk("ld011_noreq", mem_req, 0);
        chk("ld011_valid", resp_valid, 1);
        chk("ld011_err", resp_err, 1);
        chk("ld011_data", resp_data, 0);
        step();
        chk("ld011_pulse", resp_valid, 0);

        // Halfword at 0x12 is the upper half 0xF00D; byte at 0x11 is 0x80
        do_load("lhu", 3'b101, 32'h10, 32'h2, 5'd11, 32'hF00D8001,
                32'h10, 32'h0000F00D);
        do_load("lh", 3'b001, 32'h10, 32'h2, 5'd12, 32'hF00D8001,
                32'h10, 32'hFFFFF00D);
        do_load("lbu", 3'b100, 32'h10, 32'h1, 5'd13, 32'hF00D8001,
                32'h10, 32'h00000080);
        do_load("lw", 3'b010, 32'h100, 32'hFFFFFFFC, 5'd14, 32'hDEADBEEF,
                32'hFC, 32'hDEADBEEF);

        // LW timeout after 4 WAIT cycles, then a stray rvalid is ignored
        mem_ready = 1'b1;
        issue(3'b010, OP_LD, 32'h40, 32'h0, 32'h0, 5'd6);
        chk("to_req", mem_req, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait", resp_valid, 0);
            chk("to_wait_req", mem_req, 0);
            step();
        end
        chk("to_valid", resp_valid, 1);
        chk("to_err", resp_err, 1);
        chk("to_data", resp_data, 0);
        chk("to_rd", resp_rd, 0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        chk("to_idle", req_ready, 1);
        step();
        chk("to_stray", resp_valid, 0);
        mem_rvalid = 1'b0;
        step();

        // Reset in WAIT: outputs drop at once, pending rvalid ignored
        issue(3'b010, OP_LD, 32'h80, 32'h0, 32'h0, 5'd4);
        step();
        chk("mid_in_wait", mem_req, 0);
        rst_n = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("mid_ready", req_ready, 1);
        chk("mid_mem_req", mem_req, 0);
        chk("mid_resp_valid", resp_valid, 0);
        chk("mid_mem_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rvalid_ign", resp_valid, 0);
        mem_rvalid = 1'b0;

        do_store("sw1", 3'b010, 32'h300, 32'h4, 32'hCAFEF00D,
                 32'h304, 4'b1111, 32'hCAFEF00D);
        do_store("sw2", 3'b010, 32'h300, 32'h8, 32'h01234567,
                 32'h308, 4'b1111, 32'h01234567);
        do_store("sb", 3'b000, 32'h400, 32'h3, 32'h000000A7,
                 32'h400, 4'b1000, 32'hA7A7A7A7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
